// File: rtl/line_cmd_master_if.sv
// Command port and peripheral bus bundle for line_cmd_master.
// The master modport is the line_cmd_master side; the slave modport is the command source and peripheral side.
interface line_cmd_master_if #(
  parameter int COLOR_W = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [8:0]         cmd_x0;
  logic [8:0]         cmd_x1;
  logic [7:0]         cmd_y0;
  logic [7:0]         cmd_y1;
  logic [COLOR_W-1:0] cmd_color;

  logic [2:0]         m_address;
  logic               m_write;
  logic               m_read;
  logic [31:0]        m_writedata;
  logic [31:0]        m_readdata;
  logic               m_waitrequest;

  modport master (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    output cmd_ready,
    output m_address, m_write, m_read, m_writedata,
    input  m_readdata, m_waitrequest
  );

  modport slave (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    input  cmd_ready,
    input  m_address, m_write, m_read, m_writedata,
    output m_readdata, m_waitrequest
  );
endinterface

// File: rtl/line_cmd_master.sv
// Bus master that buffers line commands, programs the line peripheral's registers and polls STATUS until each line completes.
// Optional: LINE_CMD_MASTER_COLOR_CACHE_EN skips the COLOR write when the color matches the last one written.
module line_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLOR_W    = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  line_cmd_master_if.master   bus,
  output logic                busy,
  output logic [15:0]         lines_done
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = 34 + COLOR_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_W_MODE  = 3'd1;
  localparam logic [2:0] S_W_START = 3'd2;
  localparam logic [2:0] S_W_END   = 3'd3;
  localparam logic [2:0] S_W_COLOR = 3'd4;
  localparam logic [2:0] S_W_GO    = 3'd5;
  localparam logic [2:0] S_GAP     = 3'd6;
  localparam logic [2:0] S_R_STAT  = 3'd7;

  localparam logic [2:0] A_MODE   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_GO     = 3'd2;
  localparam logic [2:0] A_START  = 3'd3;
  localparam logic [2:0] A_END    = 3'd4;
  localparam logic [2:0] A_COLOR  = 3'd5;

  logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] fifo_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               cmd_ready_q, cmd_ready_d;

  logic [2:0]         state_q, state_d;
  logic               mode_written_q, mode_written_d;
  logic [15:0]        lines_done_q, lines_done_d;

  logic               m_write_q, m_write_d;
  logic               m_read_q, m_read_d;
  logic [2:0]         m_address_q, m_address_d;
  logic [31:0]        m_writedata_q, m_writedata_d;

  logic               push;
  logic               pop;
  logic               skip_color;
  logic               unused_readdata;

  logic [ENTRY_W-1:0] head;
  logic [8:0]         head_x0, head_x1;
  logic [7:0]         head_y0, head_y1;
  logic [COLOR_W-1:0] head_color;

  // Entry layout {color, y1, x1, y0, x0}
  assign head       = fifo_q[rd_ptr_q];
  assign head_x0    = head[8:0];
  assign head_y0    = head[16:9];
  assign head_x1    = head[25:17];
  assign head_y1    = head[33:26];
  assign head_color = head[ENTRY_W-1:34];

  assign push = bus.cmd_valid && cmd_ready_q;
  assign unused_readdata = ^bus.m_readdata[31:1];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {bus.cmd_color, bus.cmd_y1, bus.cmd_x1, bus.cmd_y0, bus.cmd_x0};
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_d + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_d - CW'(1);
    end
    // Registered ready: a pop on a full FIFO only reopens the port next cycle
    cmd_ready_d = (count_d != DEPTH_C);
  end

`ifdef LINE_CMD_MASTER_COLOR_CACHE_EN
  logic [COLOR_W-1:0] color_cache_q, color_cache_d;
  logic               color_valid_q, color_valid_d;

  assign skip_color = color_valid_q && (color_cache_q == head_color);

  always_comb begin
    color_cache_d = color_cache_q;
    color_valid_d = color_valid_q;
    if (state_q == S_W_COLOR && !bus.m_waitrequest) begin
      color_cache_d = head_color;
      color_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      color_cache_q <= '0;
      color_valid_q <= 1'b0;
    end else begin
      color_cache_q <= color_cache_d;
      color_valid_q <= color_valid_d;
    end
  end
`else
  assign skip_color = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    mode_written_d = mode_written_q;
    lines_done_d   = lines_done_q;
    pop            = 1'b0;
    case (state_q)
      S_IDLE:    if (count_q != '0) state_d = mode_written_q ? S_W_START : S_W_MODE;
      S_W_MODE:  if (!bus.m_waitrequest) begin
                   state_d        = S_W_START;
                   mode_written_d = 1'b1;
                 end
      S_W_START: if (!bus.m_waitrequest) state_d = S_W_END;
      S_W_END:   if (!bus.m_waitrequest) state_d = skip_color ? S_W_GO : S_W_COLOR;
      S_W_COLOR: if (!bus.m_waitrequest) state_d = S_W_GO;
      S_W_GO:    if (!bus.m_waitrequest) state_d = S_GAP;
      S_GAP:     state_d = S_R_STAT;
      S_R_STAT:  if (!bus.m_waitrequest && !bus.m_readdata[0]) begin
                   pop          = 1'b1;
                   lines_done_d = lines_done_q + 16'd1;
                   state_d      = S_IDLE;
                 end
      default:   state_d = S_IDLE;
    endcase
  end

  // Bus outputs follow the next state, so a stalled state re-registers identical values
  always_comb begin
    m_write_d     = 1'b0;
    m_read_d      = 1'b0;
    m_address_d   = A_MODE;
    m_writedata_d = '0;
    case (state_d)
      S_W_MODE: begin
        m_write_d     = 1'b1;
        m_address_d   = A_MODE;
        m_writedata_d = 32'd1;
      end
      S_W_START: begin
        m_write_d     = 1'b1;
        m_address_d   = A_START;
        m_writedata_d = {15'b0, head_y0, head_x0};
      end
      S_W_END: begin
        m_write_d     = 1'b1;
        m_address_d   = A_END;
        m_writedata_d = {15'b0, head_y1, head_x1};
      end
      S_W_COLOR: begin
        m_write_d     = 1'b1;
        m_address_d   = A_COLOR;
        m_writedata_d = 32'(head_color);
      end
      S_W_GO: begin
        m_write_d     = 1'b1;
        m_address_d   = A_GO;
        m_writedata_d = '0;
      end
      S_R_STAT: begin
        m_read_d    = 1'b1;
        m_address_d = A_STATUS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      cmd_ready_q    <= 1'b0;
      state_q        <= S_IDLE;
      mode_written_q <= 1'b0;
      lines_done_q   <= '0;
      m_write_q      <= 1'b0;
      m_read_q       <= 1'b0;
      m_address_q    <= '0;
      m_writedata_q  <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      cmd_ready_q    <= cmd_ready_d;
      state_q        <= state_d;
      mode_written_q <= mode_written_d;
      lines_done_q   <= lines_done_d;
      m_write_q      <= m_write_d;
      m_read_q       <= m_read_d;
      m_address_q    <= m_address_d;
      m_writedata_q  <= m_writedata_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.m_write     = m_write_q;
  assign bus.m_read      = m_read_q;
  assign bus.m_address   = m_address_q;
  assign bus.m_writedata = m_writedata_q;
  assign busy            = (state_q != S_IDLE) || (count_q != '0);
  assign lines_done      = lines_done_q;

endmodule

// File: doc/line_cmd_master.md
# line_cmd_master

Bus-master front end for the memory-mapped line-drawing peripheral. It accepts line commands on a valid/ready port and buffers them in a small FIFO. For each command it drives Avalon-MM-style writes into the peripheral's register file, then polls STATUS until the line completes. It sits between the command source (CPU-side bridge or test sequencer) and the peripheral's slave port.

## Interface
- FIFO_DEPTH, 4: command FIFO entries; power of 2, ≥2.
- COLOR_W, 3: color field width.
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full; reset 0.
- cmd_x0, cmd_x1  in  9  start/end x.
- cmd_y0, cmd_y1  in  8  start/end y.
- cmd_color  in  COLOR_W  line color.
- m_address  out  3  peripheral word address; reset 0.
- m_write, m_read  out  1  bus strobes; reset 0; never both high.
- m_writedata  out  32  write data; reset 0.
- m_readdata  in  32  read data; sampled when m_read=1 and m_waitrequest=0.
- m_waitrequest  in  1  slave stall.
- busy  out  1  FSM not IDLE or FIFO non-empty; reset 0.
- lines_done  out  16  completed-line count; reset 0; wraps 0xFFFF→0.

## Operation
- Peripheral word map: 0 MODE, 1 STATUS (bit0 = busy), 2 GO, 3 START, 4 END, 5 COLOR.
- START/END data: {15'b0, y[7:0], x[8:0]}. COLOR data: zero-extended color. MODE data: 1 (poll mode). GO data: 0 (any write starts the line).
- FIFO: push on cmd_valid && cmd_ready. cmd_ready = !full. When full, a same-cycle pop does not admit a push; cmd_ready stays low that cycle.
- Pop occurs only at line completion. The head entry stays stable while it is being issued.
- FSM states: IDLE, W_MODE, W_START, W_END, W_COLOR, W_GO, GAP, R_STAT.
- IDLE→W_MODE when the FIFO is non-empty and mode_written=0.
- IDLE→W_START when the FIFO is non-empty and mode_written=1.
- W_MODE→W_START; sets mode_written.
- W_START→W_END→W_COLOR→W_GO→GAP→R_STAT.
- R_STAT with readdata bit0=1 → R_STAT, with a new read issued the next cycle.
- R_STAT with bit0=0 → pop, lines_done+1, then IDLE.
- Every bus state advances only on the edge where m_waitrequest=0. Address, data, and strobe are held constant while m_waitrequest=1.
- GAP: one cycle with no strobe, so the peripheral can raise busy after GO.
- Reset mid-operation: returns to IDLE, deasserts strobes, empties the FIFO, clears mode_written and lines_done. The next command rewrites MODE.

## Timing
- Strobe registered; first bus cycle begins the cycle after IDLE sees the FIFO non-empty.
- A command pushed into an empty FIFO at edge N gives m_write=1 from edge N+1.
- Zero waitrequest, first command after reset, one status read: MODE N+1, START N+2, END N+3, COLOR N+4, GO N+5, GAP N+6, STATUS N+7. Pop and lines_done increment at edge N+8.
- Steady state (mode_written=1, zero wait, one poll): 7 cycles per line including IDLE.
- cmd_ready rises the cycle after the pop that un-fills the FIFO.

## Configuration
- LINE_CMD_MASTER_COLOR_CACHE_EN defined: a register holds the last written color (valid flag cleared on reset). W_COLOR is skipped (W_END→W_GO) when the head color equals the cached value and the flag is valid.
- LINE_CMD_MASTER_COLOR_CACHE_EN undefined: COLOR is written for every line.

## Test plan
- Reset then a single command x0=10,y0=20,x1=100,y1=50,color=5, zero wait, STATUS busy for 3 reads -> writes (0,1),(3,0x280A),(4,0x6464),(5,5),(2,0); 4 STATUS reads; lines_done=1; busy=0.
- Push 5 commands back-to-back with FIFO_DEPTH=4 while the first line is stalled -> cmd_ready low after 4 pushes; 5th accepted only after the first pop; all 5 completed in order; MODE written once.
- Random m_waitrequest 0–3 cycles on every transfer -> strobe/address/data stable while stalled; no transfer lost or duplicated.
- Assert reset_n=0 during W_END -> next-cycle strobes 0, busy=0, cmd_ready=0 then 1; the next command begins with the MODE write.
- Two lines same color=3 -> with macro: one COLOR write; without: two.
- lines_done preset by 65535 completions (or forced) -> next completion reads 0.
